truth_table_sweeper: RTL and testbench

//  Sequencer that characterises one 3-input gate netlist (e.g. module 0x21).

---
 rtl/truth_table_sweeper_pkg.sv | 16 +
 rtl/truth_table_sweeper_if.sv | 30 +++
 rtl/truth_table_sweeper_settle_timer.sv | 30 +++
 rtl/truth_table_sweeper.sv | 126 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state encoding
// and the truth-table width derived from the gate input count.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic int tt_width(input int nin);
      return 1 << nin;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host and gate-under-test signals of the sweeper. The master side is the
// host plus the gate; the slave side is the sweeper itself.
interface truth_table_sweeper_if #(
   parameter int NIN = 3
);
   import tt_sweep_pkg::*;

   localparam int TT_W = tt_width(NIN);

   logic            start;
   logic            abort;
   logic [TT_W-1:0] tt_expected;
   logic            gate_out;
   logic [NIN-1:0]  gate_in;
   logic            busy;
   logic            done;
   logic [TT_W-1:0] tt_captured;
   logic            match;

   modport master (
      output start, abort, tt_expected, gate_out,
      input  gate_in, busy, done, tt_captured, match
   );

   modport slave (
      input  start, abort, tt_expected, gate_out,
      output gate_in, busy, done, tt_captured, match
   );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that measures how long each input combination is held
// before the gate output is sampled; expired is high once the count reaches 0.
module settle_timer #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input combinations of a gate in ascending order, samples its
// output after a settle time, and compares the packed truth table to a target.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int NIN           = 3,
   parameter int SETTLE_CYCLES = 4
) (
   input logic                  clk,
   input logic                  rst,
   truth_table_sweeper_if.slave bus
);

   localparam int             TT_W = tt_width(NIN);
   localparam logic [NIN-1:0] LAST = NIN'(TT_W - 1);

   state_t          state;
   state_t          state_nxt;
   logic [NIN-1:0]  combo;
   logic [TT_W-1:0] tt_q;
   logic [TT_W-1:0] exp_q;
   logic            match_q;
   logic            busy_c;
   logic            done_c;
   logic            accept;
   logic            sweep_abort;
   logic            sample_go;
   logic            last_combo;
   logic            timer_load;
   logic            timer_expired;

   assign accept      = (state == IDLE) && bus.start && !bus.abort;
   assign sweep_abort = ((state == SETTLE) || (state == SAMPLE)) && bus.abort;
   assign sample_go   = (state == SAMPLE) && !bus.abort;
   assign last_combo  = (combo == LAST);
   assign timer_load  = accept || (sample_go && !last_combo);

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .en     (state == SETTLE),
      .expired(timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETTLE;
         SETTLE: begin
            if (bus.abort)          state_nxt = IDLE;
            else if (timer_expired) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (bus.abort)       state_nxt = IDLE;
            else if (last_combo) state_nxt = DONE;
            else                 state_nxt = SETTLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state)
         SETTLE, SAMPLE: busy_c = 1'b1;
         DONE:           done_c = 1'b1;
         default:        ;
      endcase
   end

   // The target word is only captured on an accepted start, so a start seen
   // mid-sweep cannot disturb the comparison.
   always_ff @(posedge clk) begin
      if (accept) begin
         exp_q <= bus.tt_expected;
      end
   end

   // Combo 0 lands in the MSB. The final sample is folded straight into the
   // compare so match is ready in the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         combo   <= '0;
         tt_q    <= '0;
         match_q <= 1'b0;
      end else if (accept) begin
         combo <= '0;
         tt_q  <= '0;
      end else if (sweep_abort) begin
         combo   <= '0;
         match_q <= 1'b0;
      end else if (sample_go) begin
         for (int i = 0; i < TT_W; i++) begin
            if (NIN'(TT_W - 1 - i) == combo) begin
               tt_q[i] <= bus.gate_out;
            end
         end
         if (last_combo) begin
            combo   <= '0;
            match_q <= ({tt_q[TT_W-1:1], bus.gate_out} == exp_q);
         end else begin
            combo <= combo + NIN'(1);
         end
      end
   end

   assign bus.gate_in     = combo;
   assign bus.busy        = busy_c;
   assign bus.done        = done_c;
   assign bus.tt_captured = tt_q;
   assign bus.match       = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (settle 4 and 1)
// driven by behavioural gate tables, results checked by per-instance monitors.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   logic gsel4 = 1'b0;
   logic gsel1 = 1'b0;

   truth_table_sweeper_if #(.NIN(3)) bus4 ();
   truth_table_sweeper_if #(.NIN(3)) bus1 ();

   truth_table_sweeper #(.NIN(3), .SETTLE_CYCLES(4)) dut4 (
      .clk(clk),
      .rst(rst),
      .bus(bus4)
   );

   truth_table_sweeper #(.NIN(3), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
   );

   // sel=0: gate with truth table 0x21 ; sel=1: gate with truth table 0x84
   function automatic logic gate_model(input logic sel, input logic [2:0] x);
      logic y;
      y = 1'b0;
      if (!sel) begin
         case (x)
            3'd2, 3'd7: y = 1'b1;
            default:    y = 1'b0;
         endcase
      end else begin
         case (x)
            3'd0, 3'd5: y = 1'b1;
            default:    y = 1'b0;
         endcase
      end
      return y;
   endfunction

   assign bus4.gate_out = gate_model(gsel4, bus4.gate_in);
   assign bus1.gate_out = gate_model(gsel1, bus1.gate_in);

   typedef struct {
      logic [7:0] tt;
      logic       m;
      int         t0;
      int         lat;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   exp_t e4;
   exp_t e1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus4.done === 1'b1) begin
         check("s4_done_pending", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            check("s4_tt_captured", 32'(bus4.tt_captured), 32'(e4.tt));
            check("s4_match", 32'(bus4.match), 32'(e4.m));
            check("s4_latency", 32'(cyc - e4.t0), 32'(e4.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (bus1.done === 1'b1) begin
         check("s1_done_pending", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            e1 = q1.pop_front();
            check("s1_tt_captured", 32'(bus1.tt_captured), 32'(e1.tt));
            check("s1_match", 32'(bus1.match), 32'(e1.m));
            check("s1_latency", 32'(cyc - e1.t0), 32'(e1.lat));
         end
      end
   end

   task automatic issue_start(input bit s1, input logic [7:0] w, input bit push,
                              input logic [7:0] tt, input logic m);
      exp_t e;
      @(negedge clk);
      if (s1) begin
         bus1.start       = 1'b1;
         bus1.tt_expected = w;
      end else begin
         bus4.start       = 1'b1;
         bus4.tt_expected = w;
      end
      if (push) begin
         e.tt  = tt;
         e.m   = m;
         e.t0  = cyc;
         e.lat = s1 ? 17 : 41;
         if (s1) q1.push_back(e);
         else    q4.push_back(e);
      end
      @(negedge clk);
      bus1.start = 1'b0;
      bus4.start = 1'b0;
   endtask

   task automatic wait_done(input bit s1, input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = s1 ? bus1.done : bus4.done;
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic check_idle4(input string name, input logic [7:0] tt, input logic m);
      check({name, "_busy"}, 32'(bus4.busy), 32'd0);
      check({name, "_done"}, 32'(bus4.done), 32'd0);
      check({name, "_gate_in"}, 32'(bus4.gate_in), 32'd0);
      check({name, "_tt"}, 32'(bus4.tt_captured), 32'(tt));
      check({name, "_match"}, 32'(bus4.match), 32'(m));
   endtask

   initial begin
      bus4.start = 1'b0; bus4.abort = 1'b0; bus4.tt_expected = 8'h00;
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.tt_expected = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle4("reset_s4", 8'h00, 1'b0);
      check("reset_s1_outputs",
            32'({bus1.busy, bus1.done, bus1.gate_in, bus1.tt_captured, bus1.match}), 32'd0);
      rst = 1'b0;

      // gate 0x21, matching target, with per-cycle gate_in/busy trace
      issue_start(1'b0, 8'h21, 1'b1, 8'h21, 1'b1);
      for (int k = 1; k <= 41; k++) begin
         if (k > 1) @(negedge clk);
         if (k <= 40)
            check("sweep_busy_gate_in", 32'({bus4.busy, bus4.gate_in}), 32'({1'b1, 3'((k - 1) / 5)}));
         else
            check("done_cycle_busy_gate_in", 32'({bus4.busy, bus4.gate_in}), 32'd0);
      end
      check("done_cycle_done", 32'(bus4.done), 32'd1);
      @(negedge clk);
      check("done_pulse_width", 32'(bus4.done), 32'd0);
      check("hold_after_done_tt", 32'(bus4.tt_captured), 32'h21);
      check("hold_after_done_match", 32'(bus4.match), 32'd1);

      // same gate, non-matching target
      issue_start(1'b0, 8'h84, 1'b1, 8'h21, 1'b0);
      wait_done(1'b0, "mismatch");

      // gate 0x84, matching target
      gsel4 = 1'b1;
      issue_start(1'b0, 8'h84, 1'b1, 8'h84, 1'b1);
      wait_done(1'b0, "gate84");
      gsel4 = 1'b0;

      // abort in the 3rd settle cycle of combo 3
      issue_start(1'b0, 8'h21, 1'b0, 8'h00, 1'b0);
      repeat (17) @(negedge clk);
      check("pre_abort_busy_gate_in", 32'({bus4.busy, bus4.gate_in}), 32'({1'b1, 3'd3}));
      bus4.abort = 1'b1;
      @(negedge clk);
      bus4.abort = 1'b0;
      check_idle4("after_abort", 8'h20, 1'b0);
      repeat (45) @(negedge clk);

      // abort and start together in idle: nothing starts
      @(negedge clk);
      bus4.start = 1'b1; bus4.abort = 1'b1; bus4.tt_expected = 8'h21;
      @(negedge clk);
      bus4.start = 1'b0; bus4.abort = 1'b0;
      check_idle4("abort_start_idle", 8'h20, 1'b0);
      repeat (45) @(negedge clk);
      check("abort_start_still_idle", 32'(bus4.busy), 32'd0);

      // start pulsed mid-sweep with a different target is ignored
      issue_start(1'b0, 8'h21, 1'b1, 8'h21, 1'b1);
      repeat (8) @(negedge clk);
      bus4.start = 1'b1; bus4.tt_expected = 8'h00;
      @(negedge clk);
      bus4.start = 1'b0;
      wait_done(1'b0, "restart_ignored");
      repeat (45) @(negedge clk);

      // reset mid-sweep, then a clean sweep
      issue_start(1'b0, 8'h21, 1'b0, 8'h00, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle4("mid_reset", 8'h00, 1'b0);
      repeat (45) @(negedge clk);
      issue_start(1'b0, 8'h21, 1'b1, 8'h21, 1'b1);
      wait_done(1'b0, "after_reset");

      // settle of one cycle
      gsel1 = 1'b0;
      issue_start(1'b1, 8'h21, 1'b1, 8'h21, 1'b1);
      wait_done(1'b1, "s1_gate21");
      gsel1 = 1'b1;
      issue_start(1'b1, 8'h21, 1'b1, 8'h84, 1'b0);
      wait_done(1'b1, "s1_gate84");
      @(negedge clk);
      check("s1_done_pulse_width", 32'(bus1.done), 32'd0);

      repeat (3) @(negedge clk);
      check("s4_queue_drained", 32'(q4.size()), 32'd0);
      check("s1_queue_drained", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
